// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with stall, flush, bubble and MADD/MSUB state feedback
//   in : clk, rst (sync, active-high), stall_ex, stall_mem, flush,
//        ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop,
//        ex_mem_addr, ex_reg2, ex_hilo_temp, ex_cnt
//   out: mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
//        mem_mem_addr, mem_reg2, mem_valid, hilo_temp_o, cnt_o
module ex_mem_pipe #(
    parameter int DATA_W    = 32,
    parameter int REGADDR_W = 5,
    parameter int ALUOP_W   = 8,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_ex,
    input  logic                 stall_mem,
    input  logic                 flush,
    input  logic [REGADDR_W-1:0] ex_wd,
    input  logic                 ex_wreg,
    input  logic [DATA_W-1:0]    ex_wdata,
    input  logic                 ex_whilo,
    input  logic [DATA_W-1:0]    ex_hi,
    input  logic [DATA_W-1:0]    ex_lo,
    input  logic [ALUOP_W-1:0]   ex_aluop,
    input  logic [DATA_W-1:0]    ex_mem_addr,
    input  logic [DATA_W-1:0]    ex_reg2,
    input  logic [2*DATA_W-1:0]  ex_hilo_temp,
    input  logic [CNT_W-1:0]     ex_cnt,
    output logic [REGADDR_W-1:0] mem_wd,
    output logic                 mem_wreg,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 mem_whilo,
    output logic [DATA_W-1:0]    mem_hi,
    output logic [DATA_W-1:0]    mem_lo,
    output logic [ALUOP_W-1:0]   mem_aluop,
    output logic [DATA_W-1:0]    mem_mem_addr,
    output logic [DATA_W-1:0]    mem_reg2,
    output logic                 mem_valid,
    output logic [2*DATA_W-1:0]  hilo_temp_o,
    output logic [CNT_W-1:0]     cnt_o
);
    logic w_bubble;
    logic w_advance;
    assign w_bubble  = stall_ex && !stall_mem;
    assign w_advance = !stall_ex;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            mem_valid    <= 1'b0;
            hilo_temp_o  <= '0;
            cnt_o        <= '0;
        end else if (w_bubble) begin
            // NOP goes downstream while EX keeps its multi-cycle state alive
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            mem_valid    <= 1'b0;
            hilo_temp_o  <= ex_hilo_temp;
            cnt_o        <= ex_cnt;
        end else if (w_advance) begin
            mem_wd       <= ex_wd;
            mem_wreg     <= ex_wreg;
            mem_wdata    <= ex_wdata;
            mem_whilo    <= ex_whilo;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
            mem_valid    <= 1'b1;
            hilo_temp_o  <= '0;
            cnt_o        <= '0;
        end
    end
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed self-checking bench for ex_mem_pipe
module tb_ex_mem_pipe;
    logic        clk = 1'b0;
    logic        rst, stall_ex, stall_mem, flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg, ex_whilo;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
    logic [7:0]  ex_aluop;
    logic [63:0] ex_hilo_temp;
    logic [1:0]  ex_cnt;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo, mem_valid;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
    int n_chk = 0;
    int n_fail = 0;
    localparam logic [7:0] SW_OP = 8'h2B;

    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
        .ex_reg2(ex_reg2), .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2), .mem_valid(mem_valid), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [7:0] aluop, input logic [31:0] addr, input logic [31:0] r2,
                          input logic [63:0] ht, input logic [1:0] cnt);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_whilo = whilo; ex_hi = hi; ex_lo = lo;
        ex_aluop = aluop; ex_mem_addr = addr; ex_reg2 = r2; ex_hilo_temp = ht; ex_cnt = cnt;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".wd"},    64'(mem_wd), 0);
        check({tag, ".wreg"},  64'(mem_wreg), 0);
        check({tag, ".wdata"}, 64'(mem_wdata), 0);
        check({tag, ".whilo"}, 64'(mem_whilo), 0);
        check({tag, ".hi"},    64'(mem_hi), 0);
        check({tag, ".lo"},    64'(mem_lo), 0);
        check({tag, ".aluop"}, 64'(mem_aluop), 0);
        check({tag, ".addr"},  64'(mem_mem_addr), 0);
        check({tag, ".reg2"},  64'(mem_reg2), 0);
        check({tag, ".valid"}, 64'(mem_valid), 0);
        check({tag, ".htemp"}, hilo_temp_o, 0);
        check({tag, ".cnt"},   64'(cnt_o), 0);
    endtask

    initial begin
        rst = 1; flush = 0; stall_ex = 0; stall_mem = 0;
        set_ex(5'd17, 1, 32'hCAFEF00D, 1, 32'h11, 32'h22, 8'h23, 32'h44, 32'h55, 64'h99, 2'd3);
        tick(); tick();
        check_zero("reset");
        rst = 0;
        set_ex(5'd5, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 64'hABCD, 2'd2);
        tick();
        check("adv.wd", 64'(mem_wd), 5);
        check("adv.wreg", 64'(mem_wreg), 1);
        check("adv.wdata", 64'(mem_wdata), 64'hDEADBEEF);
        check("adv.valid", 64'(mem_valid), 1);
        check("adv.htemp", hilo_temp_o, 0);
        check("adv.cnt", 64'(cnt_o), 0);
        for (int i = 1; i <= 3; i++) begin
            ex_wdata = 32'(i);
            tick();
            check("b2b.wdata", 64'(mem_wdata), 64'(i));
        end
        stall_ex = 1;
        set_ex(5'd6, 1, 32'h77, 1, 32'h1, 32'h2, 8'h23, 32'h8, 32'h9, 64'h00000001_FFFFFFFF, 2'd1);
        tick();
        check("bub.wreg", 64'(mem_wreg), 0);
        check("bub.whilo", 64'(mem_whilo), 0);
        check("bub.valid", 64'(mem_valid), 0);
        check("bub.wd", 64'(mem_wd), 0);
        check("bub.wdata", 64'(mem_wdata), 0);
        check("bub.aluop", 64'(mem_aluop), 0);
        check("bub.htemp", hilo_temp_o, 64'h00000001_FFFFFFFF);
        check("bub.cnt", 64'(cnt_o), 1);
        ex_hilo_temp = 64'h80000000_00000002; ex_cnt = 2'd2;
        tick();
        check("bub2.htemp", hilo_temp_o, 64'h80000000_00000002);
        check("bub2.cnt", 64'(cnt_o), 2);
        stall_ex = 0;
        set_ex(5'd0, 0, 0, 1, 32'd7, 32'd8, 0, 0, 0, 64'h5, 2'd1);
        tick();
        check("rel.whilo", 64'(mem_whilo), 1);
        check("rel.hi", 64'(mem_hi), 7);
        check("rel.lo", 64'(mem_lo), 8);
        check("rel.htemp", hilo_temp_o, 0);
        check("rel.cnt", 64'(cnt_o), 0);
        check("rel.valid", 64'(mem_valid), 1);
        set_ex(5'd9, 1, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        stall_ex = 1; stall_mem = 1;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'(i + 20), 1, 32'hFFFF0000 + 32'(i), 1, 32'(i), 32'(i), 8'(i), 32'(i), 32'(i), 64'(i + 40), 2'(i + 1));
            tick();
            check("hold.wd", 64'(mem_wd), 9);
            check("hold.wdata", 64'(mem_wdata), 64'h1234);
            check("hold.valid", 64'(mem_valid), 1);
            check("hold.cnt", 64'(cnt_o), 0);
        end
        stall_mem = 0;
        ex_hilo_temp = 64'h0000_0003_0000_0004; ex_cnt = 2'd1;
        tick();
        check("mid.cnt", 64'(cnt_o), 1);
        stall_mem = 1;
        ex_hilo_temp = 64'hFFFF; ex_cnt = 2'd3;
        tick();
        check("hold2.cnt", 64'(cnt_o), 1);
        check("hold2.htemp", hilo_temp_o, 64'h0000_0003_0000_0004);
        stall_mem = 0; flush = 1;
        tick();
        check_zero("flush");
        flush = 0; stall_ex = 0; rst = 1;
        set_ex(5'd12, 1, 32'h55AA, 1, 32'h3, 32'h4, SW_OP, 32'h200, 32'hBB, 64'h7, 2'd2);
        tick();
        check_zero("rstwin");
        rst = 0;
        set_ex(5'd0, 0, 0, 0, 0, 0, SW_OP, 32'h100, 32'hAA, 0, 0);
        tick();
        check("sw.aluop", 64'(mem_aluop), 64'(SW_OP));
        check("sw.addr", 64'(mem_mem_addr), 64'h100);
        check("sw.reg2", 64'(mem_reg2), 64'hAA);
        check("sw.wreg", 64'(mem_wreg), 0);
        check("sw.valid", 64'(mem_valid), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
